dmux_rx_buffer: RTL
===================

// Module: dmux_rx_buffer
// PURPOSE
//  Receive-side buffer placed directly downstream of async_dmux, in the
//  destination (q) clock domain. async_dmux delivers single-cycle val/data
//  pulses with no backpressure. This block captures each pulse into a small
//  FIFO and re-presents the data on a valid/ready handshake for the consumer.
//  Pulses that arrive while the FIFO is full are dropped, flagged and counted.
// PARAMETERS
//  DW     32  data width; must match async_dmux q width
//  DEPTH  4   FIFO entries; power of two, >=2
//  AW     2   pointer width = log2(DEPTH)
// PORTS
//  clk        in   1      destination-domain clock (async_dmux clk_q)
//  rst        in   1      synchronous reset, active-high
//  val_i      in   1      capture strobe (async_dmux val_q), 1-cycle pulse
//  d_i        in   DW     capture data (async_dmux q), valid when val_i=1
//  out_valid  out  1      head entry available
//  out_ready  in   1      consumer accepts head when out_valid&out_ready
//  out_data   out  DW     head entry data; 0 when out_valid=0
//  count      out  AW+1   current occupancy, 0..DEPTH
//  overflow   out  1      sticky: at least one pulse dropped
//  ovf_clr    in   1      clears overflow and drop_cnt
//  drop_cnt   out  8      dropped-pulse count, saturates at 8'hFF
// BEHAVIOUR
//  - Reset, sampled on posedge clk with rst=1: wptr=rptr=0, count=0,
//    out_valid=0, out_data=0, overflow=0, drop_cnt=0. Storage is not reset.
//  - pop  = out_valid & out_ready.
//  - push = val_i & (count<DEPTH | pop).
//  - A push writes mem[wptr]<=d_i and increments wptr, wrapping modulo DEPTH.
//  - A pop increments rptr, wrapping modulo DEPTH.
//  - count_next = count + push - pop. Push and pop may occur in the same
//    cycle at any occupancy, including full.
//  - Latency: a push at edge N gives out_valid=1 after edge N. There is no
//    same-cycle bypass, so an empty FIFO with val_i=1 keeps out_valid=0
//    in that cycle.
//  - out_valid = (count!=0).
//  - out_data = mem[rptr] when out_valid, else 0. Output is first-word
//    fall-through, read combinationally from registered storage.
//  - out_data stays stable while out_valid=1 and out_ready=0.
//  - Drop: val_i=1 with count==DEPTH and no pop.
//    - Data is discarded; pointers and count are unchanged.
//    - overflow<=1; drop_cnt<=drop_cnt+1, held at 8'hFF once saturated.
//  - ovf_clr=1 clears overflow and drop_cnt next edge. If a drop occurs in
//    the same cycle, the drop wins: overflow=1, drop_cnt=1.
//  - out_ready while out_valid=0 is ignored.
//  - rst asserted mid-operation flushes all entries and clears the flags
//    at that edge. Any val_i in that cycle is lost and not counted.
//  - Order preserved strictly: output order == capture order.
// TESTING
//  1 rst=1 2 cycles -> out_valid=0, count=0, out_data=0, overflow=0,
//    drop_cnt=0.
//  2 val_i pulses with 1,2,3, out_ready=0 -> count=3, out_data=1; then
//    out_ready=1 -> 1,2,3 on successive edges, out_valid=0 after the 3rd.
//  3 out_ready=0, push 1..6 (DEPTH=4) -> count=4, overflow=1, drop_cnt=2;
//    drain -> 1,2,3,4 only.
//  4 full FIFO holding 1..4, val_i=1 with d_i=9 and out_ready=1 in the same
//    cycle -> no drop, count=4, drained sequence 2,3,4,9.
//  5 overflow=1, drop_cnt=2; assert ovf_clr alone -> 0/0; assert ovf_clr
//    together with a drop -> overflow=1, drop_cnt=1.
//  6 rst while count=3 -> next cycle count=0, out_valid=0; next push of
//    h5 -> out_data=h5. Also 260 drops -> drop_cnt=8'hFF.

Source files
------------

// File: rtl/dmux_rx_buffer.sv
// Receive buffer behind async_dmux: captures single-cycle val/data pulses into a
// small FIFO and re-presents them on a valid/ready handshake, counting drops.
module dmux_rx_buffer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          val_i,
  input  logic [DW-1:0] d_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  DROP_MAX = 8'hFF;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees the slot this cycle, so a full FIFO can still accept a pulse.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = out_valid & out_ready;
  assign w_push = val_i & (~w_full | w_pop);
  assign w_drop = val_i & w_full & ~w_pop;

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // Storage is intentionally not reset; the reset cycle's pulse is discarded.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (ovf_clr) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != DROP_MAX) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

endmodule
